// File: rtl/match_matrix_decoder.sv
// Decodes a 25-bit pairwise match matrix into a canonical 5-bit symbol and scans
// every row for consistency, reporting the first bad row and keeping a saturating error tally.
module match_matrix_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_bits,
  output logic             out_err,
  output logic [2:0]       out_err_row,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [24:0]      match_q;
  logic [4:0]       sym_q;
  logic [2:0]       row_q;
  logic             err_q;
  logic [2:0]       err_row_q;
  logic [ERR_W-1:0] err_count_q;

  logic [4:0]       row_bits;
  logic [4:0]       row_expect;
  logic             row_sym;
  logic             row_fail;
  logic             last_row;

  // Row r must claim equality exactly where the recovered symbols agree,
  // which also enforces the diagonal and symmetry.
  always_comb begin
    row_bits   = '0;
    row_sym    = 1'b0;
    row_expect = '0;
    for (int r = 0; r < 5; r++) begin
      if (row_q == 3'(r)) begin
        row_bits = match_q[5*r +: 5];
        row_sym  = sym_q[r];
      end
    end
    for (int j = 0; j < 5; j++) begin
      row_expect[j] = (row_sym == sym_q[j]);
    end
    row_fail = (row_bits != row_expect);
  end

  assign last_row = (row_q == 3'd4);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = SCAN;
      SCAN:    if (last_row)  state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The symbol is taken from row 0: s[j] differs from s[0]=0 whenever a and s[j] don't match.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q     <= '0;
      sym_q       <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      err_row_q   <= '0;
      err_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            match_q   <= in_match;
            sym_q     <= {~in_match[4:1], 1'b0};
            row_q     <= '0;
            err_q     <= 1'b0;
            err_row_q <= '0;
          end
        end
        SCAN: begin
          row_q <= last_row ? 3'd0 : row_q + 3'd1;
          if (row_fail && !err_q) begin
            err_q     <= 1'b1;
            err_row_q <= row_q;
          end
          if (last_row && (err_q || row_fail) && (err_count_q != ERR_MAX)) begin
            err_count_q <= err_count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == HOLD);
  assign out_bits    = sym_q;
  assign out_err     = err_q;
  assign out_err_row = err_row_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_match_matrix_decoder.sv
// Bench for match_matrix_decoder: fixed vectors, reset/saturation sequences and
// random matrices checked against an equivalence-class reference model.
module tb_match_matrix_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [24:0] in_match;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [4:0]  out_bits;
  logic [2:0]  out_err_row;
  logic [7:0]  err_count;

  logic        sat_in_ready, sat_out_valid, sat_out_err;
  logic [4:0]  sat_out_bits;
  logic [2:0]  sat_out_err_row;
  logic [1:0]  sat_err_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int exp_sat = 0;

  always #5 clk = ~clk;

  match_matrix_decoder #(.ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_match(in_match), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_err(out_err), .out_err_row(out_err_row),
    .err_count(err_count)
  );

  match_matrix_decoder #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_match(in_match), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_bits(sat_out_bits), .out_err(sat_out_err), .out_err_row(sat_out_err_row),
    .err_count(sat_err_count)
  );

  typedef struct {
    logic [24:0] match;
    logic [4:0]  bits;
    logic        err;
    logic [2:0]  row;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  // Matrix that a given 5-symbol word would produce if every claim were true.
  function automatic logic [24:0] build_matrix(input logic [4:0] sym);
    logic [24:0] m;
    m = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        m[5*i+j] = (sym[i] == sym[j]);
    return m;
  endfunction

  // Reference: canonical symbol from a's row, then the first row differing from the ideal matrix.
  function automatic void model(input logic [24:0] m, output logic [4:0] bits,
                                output logic err, output logic [2:0] row);
    logic [24:0] ideal;
    bits  = {~m[4:1], 1'b0};
    ideal = build_matrix(bits);
    err   = 1'b0;
    row   = '0;
    for (int r = 4; r >= 0; r--) begin
      if (m[5*r +: 5] != ideal[5*r +: 5]) begin
        err = 1'b1;
        row = 3'(r);
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_count = 0;
    exp_sat   = 0;
  endtask

  // Present a matrix until accepted, scramble inputs during the scan, and measure latency.
  task automatic apply_stimulus(input logic [24:0] m);
    int w;
    int lat;
    @(negedge clk);
    in_match = m; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_match = 25'($urandom);
    in_valid = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_match = 25'($urandom);
    end
    check("latency", lat, 5);
  endtask

  task automatic check_output(input logic [4:0] bits, input logic err, input logic [2:0] row,
                              input int hold);
    logic [4:0] snap_bits;
    logic       snap_err;
    logic [2:0] snap_row;
    int         unstable;
    if (err) begin
      if (exp_count < 255) exp_count++;
      if (exp_sat < 3) exp_sat++;
    end
    check("out_bits", out_bits, bits);
    check("out_err", out_err, err);
    check("out_err_row", out_err_row, row);
    check("err_count", err_count, exp_count);
    check("sat_err_count", sat_err_count, exp_sat);
    check("in_ready_hold", in_ready, 0);
    snap_bits = out_bits; snap_err = out_err; snap_row = out_err_row;
    if (hold > 0) begin
      unstable = 0;
      repeat (hold) begin
        @(negedge clk);
        in_match = 25'($urandom);
        if (out_bits !== snap_bits || out_err !== snap_err || out_err_row !== snap_row ||
            out_valid !== 1'b1 || in_ready !== 1'b0)
          unstable++;
      end
      check("hold_stable", unstable, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handshake_valid", out_valid, 0);
    check("handshake_ready", in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [24:0] cons;
    logic [24:0] m;
    logic [4:0]  bits;
    logic        err;
    logic [2:0]  row;
    int          seen;

    reset = 1'b1; in_valid = 1'b0; in_match = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bits", out_bits, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_err_row", out_err_row, 0);
    check("rst_err_count", err_count, 0);

    cons = build_matrix(5'b01101);
    vecs[0] = '{cons,                      5'b10010, 1'b0, 3'd0, 10};
    vecs[1] = '{25'h1FFFFFF,               5'b00000, 1'b0, 3'd0, 2};
    vecs[2] = '{25'h1FFFFBF,               5'b00000, 1'b1, 3'd1, 1};
    vecs[3] = '{cons ^ (25'd1 << 13),      5'b10010, 1'b1, 3'd2, 0};
    vecs[4] = '{25'h1FFFFFE,               5'b00000, 1'b1, 3'd0, 3};
    vecs[5] = '{cons ^ (25'd1 << 24),      5'b10010, 1'b1, 3'd4, 0};
    vecs[6] = '{25'h0000000,               5'b11110, 1'b1, 3'd0, 1};
    vecs[7] = '{cons ^ (25'd1 << 5),       5'b10010, 1'b1, 3'd1, 0};

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].match);
      check_output(vecs[i].bits, vecs[i].err, vecs[i].row, vecs[i].hold);
    end

    // Reset arriving mid-scan, together with in_valid and out_ready, discards the matrix.
    @(negedge clk);
    in_match = 25'h0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    check("midscan_in_ready", in_ready, 1);
    check("midscan_out_valid", out_valid, 0);
    check("midscan_err_count", err_count, 0);
    check("midscan_sat_count", sat_err_count, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midscan_no_output", seen, 0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(25'h0);
      check_output(5'b11110, 1'b1, 3'd0, 0);
    end
    check("saturated_count", sat_err_count, 3);
    check("unsaturated_count", err_count, 5);

    for (int i = 0; i < 40; i++) begin
      m = build_matrix(5'($urandom));
      case ($urandom_range(0, 3))
        0: m = 25'($urandom);
        1: m = m ^ (25'd1 << $urandom_range(0, 24));
        2: m = m ^ (25'd1 << $urandom_range(0, 24)) ^ (25'd1 << $urandom_range(0, 24));
        default: ;
      endcase
      model(m, bits, err, row);
      apply_stimulus(m);
      check_output(bits, err, row, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_matrix_decoder.md
MATCH_MATRIX_DECODER -- requirements
Module: match_matrix_decoder

Interface
REQ-001 Parameter: ERR_W, default 8, width of the saturating error counter (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer presents a 25-bit pairwise match matrix.
REQ-005 in_ready  output  1  decoder can accept a matrix this cycle.
REQ-006 in_match  input  25  match matrix; bit 5*i+j claims (s[i]==s[j]), i,j in 0..4, where s[0]=a through s[4]=e.
REQ-007 out_valid  output  1  decoded result is available.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_bits  output  5  canonical recovered symbol; out_bits[i]=s[i], with out_bits[0] always 0.
REQ-010 out_err  output  1  the matrix is inconsistent with out_bits.
REQ-011 out_err_row  output  3  lowest failing row index (0..4); 0 when out_err=0.
REQ-012 err_count  output  ERR_W  number of results completed with out_err=1, saturating.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN and HOLD, with in_ready=1 only in IDLE and out_valid=1 only in HOLD.
REQ-014 IDLE: on an edge with in_valid=1, the block SHALL register in_match and derive s[0]=0 and s[j]=~in_match[j] for j=1..4, then set row=0 and go to SCAN.
REQ-015 SCAN: each edge SHALL check one row r with the rule in_match[5r+j]==(s[r]==s[j]) for all j in 0..4, then increment r.
REQ-016 This rule SHALL also cover the diagonal bits (these must equal 1) and symmetry.
REQ-017 On the first failing row, the block SHALL latch err=1 and err_row=r; later failures SHALL NOT overwrite err_row.
REQ-018 The edge that checks row 4 SHALL move the FSM to HOLD, so out_valid rises exactly 5 edges after the accepting edge.
REQ-019 On the edge entering HOLD with err=1, err_count SHALL increment, saturating at 2^ERR_W-1 with no wrap.
REQ-020 HOLD: out_bits, out_err and out_err_row SHALL remain stable while out_ready=0, for any duration.
REQ-021 An edge in HOLD with out_ready=1 SHALL return the FSM to IDLE.
REQ-022 Throughput SHALL be one matrix per 7 cycles minimum, with no overlap of acceptance and output.
REQ-023 in_valid asserted outside IDLE SHALL be ignored; the producer holds it until in_ready=1.
REQ-024 in_match SHALL be sampled only on the accepting edge; changes during SCAN or HOLD SHALL have no effect.
REQ-025 out_bits, out_err and out_err_row SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-026 While reset=1 at an edge, the block SHALL go to IDLE with in_ready=1, out_valid=0, out_bits=0, out_err=0, out_err_row=0, err_count=0 and row=0.
REQ-027 Reset in SCAN or HOLD SHALL abort the matrix in flight and produce no output for it.
REQ-028 Reset SHALL take priority over any simultaneous in_valid or out_ready.
REQ-029 err_count SHALL be cleared only by reset.

Verification
REQ-030 Consistent input: matrix built from a=1,b=0,c=1,d=1,e=0 -> out_valid 5 edges after acceptance, out_bits=5'b10010, out_err=0, err_count unchanged.
REQ-031 All-ones input: in_match=25'h1FFFFFF -> out_bits=0, out_err=0, out_err_row=0.
REQ-032 Fault injection: clear bit 6 of the all-ones matrix -> out_err=1, out_err_row=1, err_count +1.
REQ-033 Fault injection: flip bit 13 of a consistent matrix -> out_err=1, out_err_row=2.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in HOLD -> outputs stable and in_ready=0 throughout; the handshake edge returns the FSM to IDLE.
REQ-035 Reset mid-SCAN -> next cycle in_ready=1, out_valid=0, err_count=0.
REQ-036 Saturation: ERR_W=2 with five faulty matrices -> err_count ends at 3.
